rtc_timekeeper: RTL and testbench

Parametrised time-of-day counter producing hours, minutes and seconds from the system clock through an internal prescaler. It replaces the fixed ripple-divider clock with a fully synchronous design. It adds run control, time load with range checking, 12/24-hour display, a day-wrap pulse and an hour:minute alarm. It sits between the system clock domain and the display/alarm logic of the clock subsystem.

---
 rtl/rtc_timekeeper_if.sv | 31 +++
 rtl/rtc_timekeeper.sv | 118 +++++++++++
 tb/tb_rtc_timekeeper.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_timekeeper_if.sv
// Control/load/alarm inputs and time/pulse outputs of the RTC timekeeper.
// The master side drives the controls; the slave side (the timekeeper) drives time and pulses.
interface rtc_timekeeper_if;
  logic       run;
  logic       mode_12h;
  logic       load;
  logic [5:0] set_hr;
  logic [6:0] set_min;
  logic [6:0] set_sec;
  logic       alarm_en;
  logic [5:0] alarm_hr;
  logic [6:0] alarm_min;
  logic [5:0] hr;
  logic [6:0] min;
  logic [6:0] sec;
  logic       pm;
  logic       sec_tick;
  logic       day_tick;
  logic       alarm;
  logic       load_err;

  modport master (
    output run, mode_12h, load, set_hr, set_min, set_sec, alarm_en, alarm_hr, alarm_min,
    input  hr, min, sec, pm, sec_tick, day_tick, alarm, load_err
  );

  modport slave (
    input  run, mode_12h, load, set_hr, set_min, set_sec, alarm_en, alarm_hr, alarm_min,
    output hr, min, sec, pm, sec_tick, day_tick, alarm, load_err
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// Synchronous time-of-day counter with prescaler, checked load, 12/24h display and alarm.
// Pulses are registered (one cycle after the causing edge); no backpressure, inputs sampled every cycle.
module rtc_timekeeper #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rtc_timekeeper_if.slave bus
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    hr_q, hr_d;
  logic [6:0]    min_q, min_d;
  logic [6:0]    sec_q, sec_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_tick_q, day_tick_d;
  logic          alarm_q, alarm_d;
  logic          load_err_q, load_err_d;

  logic          sec_wrap, min_wrap, hr_wrap;
  logic [5:0]    hr_n;
  logic [6:0]    min_n, sec_n;
  logic          load_ok;
  logic [5:0]    hr_disp;
  logic          pm_disp;

  assign sec_wrap = (sec_q == 7'd59);
  assign min_wrap = (min_q == 7'd59);
  assign hr_wrap  = (hr_q == 6'd23);

  // Time one second ahead of the current state
  assign sec_n = sec_wrap ? 7'd0 : sec_q + 7'd1;
  assign min_n = sec_wrap ? (min_wrap ? 7'd0 : min_q + 7'd1) : min_q;
  assign hr_n  = (sec_wrap && min_wrap) ? (hr_wrap ? 6'd0 : hr_q + 6'd1) : hr_q;

  assign load_ok = (bus.set_hr < 6'd24) && (bus.set_min < 7'd60) && (bus.set_sec < 7'd60);

  always_comb begin
    presc_d    = presc_q;
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;
    alarm_d    = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      // A load cycle always swallows a pending tick, accepted or not
      if (load_ok) begin
        hr_d    = bus.set_hr;
        min_d   = bus.set_min;
        sec_d   = bus.set_sec;
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.run) begin
      if (presc_q == TERM) begin
        presc_d    = '0;
        hr_d       = hr_n;
        min_d      = min_n;
        sec_d      = sec_n;
        sec_tick_d = 1'b1;
        day_tick_d = sec_wrap && min_wrap && hr_wrap;
        alarm_d    = bus.alarm_en && (hr_n == bus.alarm_hr) && (min_n == bus.alarm_min)
                     && (sec_n == 7'd0);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    hr_disp = hr_q;
    pm_disp = 1'b0;
    if (bus.mode_12h) begin
      pm_disp = (hr_q >= 6'd12);
      if (hr_q == 6'd0) begin
        hr_disp = 6'd12;
      end else if (hr_q > 6'd12) begin
        hr_disp = hr_q - 6'd12;
      end
    end
  end

  assign bus.hr       = hr_disp;
  assign bus.pm       = pm_disp;
  assign bus.min      = min_q;
  assign bus.sec      = sec_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_tick = day_tick_q;
  assign bus.alarm    = alarm_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: display table, hand-written corner sequences and random run vs. a seconds-count model.
module tb_rtc_timekeeper;
  localparam int TPS = 4;

  logic clk;
  logic rst_n;
  rtc_timekeeper_if bus();

  rtc_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: time as seconds since midnight, prescaler as a plain count
  int m_t, m_presc;
  bit m_st, m_dt, m_al, m_er;

  typedef struct {
    int h; int m; int s; bit mode;
    int eh; int em; int es; bit epm; bit eerr;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_update();
    int at;
    if (!rst_n) begin
      m_t = 0; m_presc = 0; m_st = 0; m_dt = 0; m_al = 0; m_er = 0;
      return;
    end
    m_st = 0; m_dt = 0; m_al = 0; m_er = 0;
    if (bus.load) begin
      if (bus.set_hr < 24 && bus.set_min < 60 && bus.set_sec < 60) begin
        m_t = int'(bus.set_hr) * 3600 + int'(bus.set_min) * 60 + int'(bus.set_sec);
        m_presc = 0;
      end else begin
        m_er = 1;
      end
    end else if (bus.run) begin
      if (m_presc == TPS - 1) begin
        m_presc = 0;
        m_t = (m_t + 1) % 86400;
        m_st = 1;
        m_dt = (m_t == 0);
        at = int'(bus.alarm_hr) * 3600 + int'(bus.alarm_min) * 60;
        m_al = bus.alarm_en && bus.alarm_hr < 24 && bus.alarm_min < 60 && (m_t == at);
      end else begin
        m_presc++;
      end
    end
  endfunction

  task automatic compare_all();
    int h24, eh;
    h24 = m_t / 3600;
    eh  = bus.mode_12h ? ((h24 % 12 == 0) ? 12 : h24 % 12) : h24;
    chk("hr", 32'(bus.hr), 32'(eh));
    chk("min", 32'(bus.min), 32'((m_t / 60) % 60));
    chk("sec", 32'(bus.sec), 32'(m_t % 60));
    chk("pm", 32'(bus.pm), 32'(bus.mode_12h && h24 >= 12));
    chk("sec_tick", 32'(bus.sec_tick), 32'(m_st));
    chk("day_tick", 32'(bus.day_tick), 32'(m_dt));
    chk("alarm", 32'(bus.alarm), 32'(m_al));
    chk("load_err", 32'(bus.load_err), 32'(m_er));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask

  task automatic set_load(input int h, input int m, input int s);
    bus.load    = 1'b1;
    bus.set_hr  = 6'(h);
    bus.set_min = 7'(m);
    bus.set_sec = 7'(s);
  endtask

  initial begin
    int ticks;
    vt[0]  = '{0, 0, 0, 1,   12, 0, 0, 0, 0};
    vt[1]  = '{11, 0, 0, 1,  11, 0, 0, 0, 0};
    vt[2]  = '{12, 0, 0, 1,  12, 0, 0, 1, 0};
    vt[3]  = '{13, 0, 0, 1,  1, 0, 0, 1, 0};
    vt[4]  = '{23, 0, 0, 1,  11, 0, 0, 1, 0};
    vt[5]  = '{23, 0, 0, 0,  23, 0, 0, 0, 0};
    vt[6]  = '{24, 0, 0, 0,  23, 0, 0, 0, 1};
    vt[7]  = '{10, 60, 0, 0, 23, 0, 0, 0, 1};
    vt[8]  = '{10, 0, 60, 0, 23, 0, 0, 0, 1};
    vt[9]  = '{12, 34, 56, 0, 12, 34, 56, 0, 0};
    vt[10] = '{63, 0, 0, 1,  12, 34, 56, 1, 1};

    rst_n = 1'b0;
    bus.run = 1'b0; bus.mode_12h = 1'b0; bus.load = 1'b0;
    bus.set_hr = '0; bus.set_min = '0; bus.set_sec = '0;
    bus.alarm_en = 1'b0; bus.alarm_hr = '0; bus.alarm_min = '0;
    m_t = 0; m_presc = 0; m_st = 0; m_dt = 0; m_al = 0; m_er = 0;

    // Reset state and free-running count
    step();
    chk("rst_hr", 32'(bus.hr), 0);
    chk("rst_sec", 32'(bus.sec), 0);
    chk("rst_tick", 32'(bus.sec_tick), 0);
    rst_n = 1'b1; bus.run = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 240; i++) begin
      step();
      ticks += int'(bus.sec_tick);
      if (i == 3) chk("sec_before_4th_edge", 32'(bus.sec), 0);
      if (i == 4) chk("sec_after_4_edges", 32'(bus.sec), 1);
    end
    chk("ticks_in_240", 32'(ticks), 60);
    chk("min_after_240", 32'(bus.min), 1);
    chk("sec_after_240", 32'(bus.sec), 0);

    // Midnight wrap
    set_load(23, 59, 58);
    step();
    bus.load = 1'b0;
    chk("wrap_load_sec", 32'(bus.sec), 58);
    repeat (4) step();
    chk("wrap_sec59", 32'(bus.sec), 59);
    repeat (4) step();
    chk("wrap_hr", 32'(bus.hr), 0);
    chk("wrap_min", 32'(bus.min), 0);
    chk("wrap_sec", 32'(bus.sec), 0);
    chk("wrap_sec_tick", 32'(bus.sec_tick), 1);
    chk("wrap_day_tick", 32'(bus.day_tick), 1);
    step();
    chk("wrap_day_tick_gone", 32'(bus.day_tick), 0);

    // Alarm by advance fires; alarm by load does not
    bus.alarm_en = 1'b1; bus.alarm_hr = 6'd7; bus.alarm_min = 7'd30;
    set_load(7, 29, 59);
    step();
    bus.load = 1'b0;
    repeat (3) step();
    chk("alarm_early", 32'(bus.alarm), 0);
    step();
    chk("alarm_fire", 32'(bus.alarm), 1);
    chk("alarm_min", 32'(bus.min), 30);
    step();
    chk("alarm_one_cycle", 32'(bus.alarm), 0);
    set_load(7, 30, 0);
    step();
    bus.load = 1'b0;
    chk("alarm_by_load", 32'(bus.alarm), 0);

    // Display and load-range table, time frozen
    bus.run = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.mode_12h = vt[i].mode;
      set_load(vt[i].h, vt[i].m, vt[i].s);
      step();
      bus.load = 1'b0;
      chk("tbl_hr", 32'(bus.hr), 32'(vt[i].eh));
      chk("tbl_min", 32'(bus.min), 32'(vt[i].em));
      chk("tbl_sec", 32'(bus.sec), 32'(vt[i].es));
      chk("tbl_pm", 32'(bus.pm), 32'(vt[i].epm));
      chk("tbl_err", 32'(bus.load_err), 32'(vt[i].eerr));
      chk("tbl_no_tick", 32'(bus.sec_tick), 0);
      step();
      chk("tbl_err_clear", 32'(bus.load_err), 0);
    end

    // run=0 freezes mid-count, then resumes from the held prescaler
    bus.mode_12h = 1'b0;
    set_load(1, 2, 3);
    step();
    bus.load = 1'b0; bus.run = 1'b1;
    repeat (2) step();
    bus.run = 1'b0;
    repeat (10) step();
    chk("frozen_sec", 32'(bus.sec), 3);
    bus.run = 1'b1;
    step();
    chk("resume_sec", 32'(bus.sec), 3);
    step();
    chk("resume_adv", 32'(bus.sec), 4);
    chk("resume_tick", 32'(bus.sec_tick), 1);

    // Load on the terminal-count cycle swallows the tick
    repeat (3) step();
    set_load(5, 6, 7);
    step();
    chk("load_tc_tick", 32'(bus.sec_tick), 0);
    chk("load_tc_sec", 32'(bus.sec), 7);

    // Held load keeps prescaler at zero
    repeat (5) step();
    bus.load = 1'b0;
    repeat (3) step();
    chk("held_load_sec", 32'(bus.sec), 7);
    step();
    chk("held_load_adv", 32'(bus.sec), 8);

    // Reset clears a live pulse, and discards a partial count
    rst_n = 1'b0;
    step();
    chk("rst_pulse_clr", 32'(bus.sec_tick), 0);
    chk("rst_sec_clr", 32'(bus.sec), 0);
    rst_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_mid_sec", 32'(bus.sec), 0);
    step();
    chk("rst_mid_adv", 32'(bus.sec), 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int at, k, t;
      rst_n = ($urandom_range(0, 299) != 0);
      bus.run = ($urandom_range(0, 9) != 0);
      bus.mode_12h = ($urandom_range(0, 15) == 0) ? ~bus.mode_12h : bus.mode_12h;
      bus.alarm_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) begin
        bus.alarm_hr  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(24, 63)) : 6'($urandom_range(0, 23));
        bus.alarm_min = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(60, 127)) : 7'($urandom_range(0, 59));
      end
      bus.load = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: set_load(int'($urandom_range(0, 63)), int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
          1: set_load(23, 59, int'($urandom_range(50, 59)));
          default: begin
            at = (int'(bus.alarm_hr) % 24) * 3600 + (int'(bus.alarm_min) % 60) * 60;
            k = int'($urandom_range(0, 3));
            t = (at - k + 86400) % 86400;
            set_load(t / 3600, (t / 60) % 60, t % 60);
          end
        endcase
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
